nbout_buffer: RTL and testbench
===============================

Name: nbout_buffer

Overview:
- Output neuron buffer (NBout) sitting directly downstream of the NFU pipeline.
- Captures Tn-wide partial sums or final results written back by the pipeline.
- Returns stored partial sums to the pipeline's NBout-to-NFU-2 load path for accumulation.
- Drains completed result rows to external memory over a valid/ready stream.

Parameters:
- BIT_WIDTH, 16, width of one neuron value.
- Tn, 16, neurons per row (row width = BIT_WIDTH*Tn).
- DEPTH, 64, number of rows stored.
- ADDR_W, 6, row address width (log2 DEPTH).

Ports:
- clk  in  1  main clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_wr_en  in  1  write a row from the pipeline output.
- i_wr_addr  in  ADDR_W  write row address.
- i_wr_data  in  BIT_WIDTH*Tn  row data from the pipeline output.
- i_rd_en  in  1  read a partial-sum row for the pipeline.
- i_rd_addr  in  ADDR_W  read row address.
- o_rd_data  out  BIT_WIDTH*Tn  row to the pipeline's NBout load input.
- o_rd_valid  out  1  o_rd_data valid this cycle.
- i_drain_start  in  1  start draining rows 0..count-1.
- i_drain_count  in  ADDR_W+1  number of rows to drain.
- o_drain_data  out  BIT_WIDTH*Tn  drain stream data.
- o_drain_valid  out  1  drain beat valid.
- i_drain_ready  in  1  downstream accepts beat.
- o_busy  out  1  drain in progress.
- o_done  out  1  one-cycle pulse, drain complete.

Behaviour:
- Reset (async, active-high): all outputs 0, FSM to IDLE, drain counters 0. Storage array is not reset; contents are undefined until written.
- Write: if i_wr_en, mem[i_wr_addr] <= i_wr_data at the clock edge. Writes are accepted in every state, including during a drain.
- Read latency:
  - If i_rd_en is high at edge N and the FSM is IDLE, o_rd_data = mem[i_rd_addr] and o_rd_valid = 1 during cycle N+1.
  - Otherwise o_rd_valid = 0 in cycle N+1, and o_rd_data holds its last value.
- Read/write collision: same-cycle i_rd_en and i_wr_en to the same address is write-first. o_rd_data returns i_wr_data.
- Read while busy: i_rd_en is ignored while o_busy = 1 (drain owns the read port), and o_rd_valid stays 0.
- FSM states:
  - IDLE:
    - i_drain_start with count 0 -> DONE.
    - i_drain_start with count > 0 -> FILL. Latch len = min(count, DEPTH) and set ptr = 0.
  - FILL: issue an internal read of mem[ptr] -> STREAM. o_busy = 1.
  - STREAM: o_drain_valid = 1 and o_drain_data = row ptr.
    - A beat transfers when valid & ready. On transfer, ptr++.
    - If ptr was len-1 -> DONE; otherwise the next row is presented the following cycle with no bubble (prefetch).
    - With valid & !ready, data and valid must hold stable.
  - DONE: o_done = 1 for exactly one cycle and o_busy = 0 -> IDLE.
- Drain timing: i_drain_start sampled at edge N gives first o_drain_valid in cycle N+2. With ready held high, len beats occur on consecutive cycles.
- Start while busy: i_drain_start is ignored while o_busy = 1 or in DONE.
- Counter widths: ptr and len are ADDR_W+1 bits so that len = DEPTH is representable. Rows are drained in increasing address order 0..len-1.
- Write during drain: if a row is written before it is prefetched, the drain returns the new data. Once prefetched, the row's beat is fixed.
- Reset mid-drain: valid, busy and done drop to 0 immediately (async). No o_done pulse is produced.

Test Plan:
1. Write rows 0..3 with values 0x0001..0x0004 in every lane, then read address 2 -> o_rd_valid one cycle later with every lane 0x0003. o_rd_valid = 0 on cycles with no read.
2. Write and read address 5 in the same cycle with data 0xABCD per lane -> next cycle o_rd_data = 0xABCD per lane (write-first).
3. Write rows 0..7, i_drain_count = 8, ready tied high -> o_busy high, 8 consecutive beats in order starting 2 cycles after start, then a single o_done pulse.
4. Same drain with i_drain_ready toggling every other cycle -> each row delivered exactly once, in order, with data stable while stalled. i_rd_en asserted during the drain produces no o_rd_valid.
5. i_drain_count = 0 -> no o_drain_valid, o_done pulses one cycle later. i_drain_count = 100 -> exactly 64 beats.
6. Assert rst after the 3rd beat of an 8-row drain -> o_drain_valid and o_busy go to 0 immediately, and no o_done. After reset, a new drain of 2 rows completes normally.

Source files
------------

// File: rtl/nbout_buffer.sv
// NBout row buffer: 1-cycle pipeline reads (write-first), writes in every state, drain streamer.
// Drain latency is start + 2 cycles to the first beat; beats hold stable while i_drain_ready is low.
module nbout_buffer #(
    parameter int BIT_WIDTH = 16,
    parameter int Tn        = 16,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wr_en,
    input  logic [ADDR_W-1:0]         i_wr_addr,
    input  logic [BIT_WIDTH*Tn-1:0]   i_wr_data,
    input  logic                      i_rd_en,
    input  logic [ADDR_W-1:0]         i_rd_addr,
    output logic [BIT_WIDTH*Tn-1:0]   o_rd_data,
    output logic                      o_rd_valid,
    input  logic                      i_drain_start,
    input  logic [ADDR_W:0]           i_drain_count,
    output logic [BIT_WIDTH*Tn-1:0]   o_drain_data,
    output logic                      o_drain_valid,
    input  logic                      i_drain_ready,
    output logic                      o_busy,
    output logic                      o_done
);
    localparam int ROW_W = BIT_WIDTH * Tn;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, DONE} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W:0]    ptr_q, ptr_d, len_q, len_d;
    logic [ADDR_W:0]    ptr_inc;
    logic [ROW_W-1:0]   mem [DEPTH];
    logic [ROW_W-1:0]   rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;
    logic [ROW_W-1:0]   drain_data_q, drain_data_d;
    logic [ADDR_W-1:0]  fetch_addr;
    logic [ROW_W-1:0]   rd_fwd, fetch_fwd;

    assign ptr_inc    = ptr_q + 1'b1;
    assign fetch_addr = (state_q == STREAM) ? ptr_inc[ADDR_W-1:0] : ptr_q[ADDR_W-1:0];

    // Both read paths forward a same-cycle write so the freshest row is always seen.
    assign rd_fwd    = (i_wr_en && (i_wr_addr == i_rd_addr))  ? i_wr_data : mem[i_rd_addr];
    assign fetch_fwd = (i_wr_en && (i_wr_addr == fetch_addr)) ? i_wr_data : mem[fetch_addr];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        len_d        = len_q;
        drain_data_d = drain_data_q;
        rd_valid_d   = i_rd_en && (state_q == IDLE);
        rd_data_d    = rd_valid_d ? rd_fwd : rd_data_q;

        case (state_q)
            IDLE: begin
                if (i_drain_start) begin
                    if (i_drain_count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                        len_d   = (i_drain_count > DEPTH_C) ? DEPTH_C : i_drain_count;
                        ptr_d   = '0;
                    end
                end
            end
            FILL: begin
                drain_data_d = fetch_fwd;
                state_d      = STREAM;
            end
            STREAM: begin
                // Next row is prefetched on the accepting edge, so beats run back-to-back.
                if (i_drain_ready) begin
                    if (ptr_q == len_q - 1'b1) begin
                        state_d = DONE;
                    end else begin
                        ptr_d        = ptr_inc;
                        drain_data_d = fetch_fwd;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            len_q        <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            drain_data_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            len_q        <= len_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            drain_data_q <= drain_data_d;
        end
    end

    assign o_rd_data     = rd_data_q;
    assign o_rd_valid    = rd_valid_q;
    assign o_drain_data  = drain_data_q;
    assign o_drain_valid = (state_q == STREAM);
    assign o_busy        = (state_q == FILL) || (state_q == STREAM);
    assign o_done        = (state_q == DONE);

endmodule

// File: tb/tb_nbout_buffer.sv
// Directed bench for nbout_buffer with read and drain scoreboards.
module tb_nbout_buffer;
    logic         clk;
    logic         rst;
    logic         i_wr_en;
    logic [5:0]   i_wr_addr;
    logic [255:0] i_wr_data;
    logic         i_rd_en;
    logic [5:0]   i_rd_addr;
    logic [255:0] o_rd_data;
    logic         o_rd_valid;
    logic         i_drain_start;
    logic [6:0]   i_drain_count;
    logic [255:0] o_drain_data;
    logic         o_drain_valid;
    logic         i_drain_ready;
    logic         o_busy;
    logic         o_done;

    nbout_buffer dut (
        .clk           (clk),
        .rst           (rst),
        .i_wr_en       (i_wr_en),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .i_rd_en       (i_rd_en),
        .i_rd_addr     (i_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_rd_valid    (o_rd_valid),
        .i_drain_start (i_drain_start),
        .i_drain_count (i_drain_count),
        .o_drain_data  (o_drain_data),
        .o_drain_valid (o_drain_valid),
        .i_drain_ready (i_drain_ready),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           total;
    int           bad;
    int           beats;
    int           done_cnt;
    bit           rd_vld_exp;
    bit           rd_expect_next;
    bit           prev_stall;
    logic [255:0] prev_data;
    logic [255:0] model [64];
    logic [255:0] rd_q [$];
    logic [255:0] drain_q [$];

    function automatic logic [255:0] row_of(input logic [15:0] v);
        return {16{v}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Checks the current cycle against the scoreboards, then advances one clock.
    task automatic tick();
        chk("rd_vld", 256'(o_rd_valid), 256'(rd_vld_exp));
        if (rd_vld_exp && rd_q.size() != 0) begin
            chk("rd_dat", o_rd_data, rd_q.pop_front());
        end
        rd_vld_exp     = rd_expect_next;
        rd_expect_next = 1'b0;
        if (o_drain_valid) begin
            if (prev_stall) begin
                chk("stall_dat", o_drain_data, prev_data);
            end
            if (i_drain_ready) begin
                if (drain_q.size() == 0) begin
                    chk("unexpected_beat", 256'(1), 256'(0));
                end else begin
                    chk("drain_dat", o_drain_data, drain_q.pop_front());
                end
                beats++;
            end
        end
        prev_stall = o_drain_valid && !i_drain_ready;
        prev_data  = o_drain_data;
        if (o_done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [255:0] d);
        i_wr_en   = 1'b1;
        i_wr_addr = 6'(addr);
        i_wr_data = d;
        model[addr] = d;
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic rd(input int addr);
        i_rd_en   = 1'b1;
        i_rd_addr = 6'(addr);
        rd_q.push_back(model[addr]);
        rd_expect_next = 1'b1;
        tick();
        i_rd_en = 1'b0;
    endtask

    task automatic drain(input int cnt, input bit toggle, input bit rd_during, input int exp_len);
        int n;
        for (int i = 0; i < exp_len; i++) drain_q.push_back(model[i]);
        beats         = 0;
        done_cnt      = 0;
        i_drain_count = 7'(cnt);
        i_drain_start = 1'b1;
        tick();
        i_drain_start = 1'b0;
        if (exp_len > 0) begin
            chk("busy_n1", 256'(o_busy), 256'(1));
            chk("dv_n1", 256'(o_drain_valid), 256'(0));
            tick();
            chk("dv_n2", 256'(o_drain_valid), 256'(1));
        end else begin
            chk("done_cnt0", 256'(o_done), 256'(1));
            chk("dv_cnt0", 256'(o_drain_valid), 256'(0));
        end
        n = 0;
        while (!o_done && n < 400) begin
            i_drain_ready = toggle ? (n % 2 == 1) : 1'b1;
            i_rd_en       = rd_during && o_busy;
            i_rd_addr     = 6'd1;
            tick();
            n++;
        end
        i_rd_en       = 1'b0;
        i_drain_ready = 1'b1;
        chk("drain_timeout", 256'(n < 400), 256'(1));
        if (!toggle) chk("consecutive", 256'(n), 256'(exp_len));
        tick();
        chk("done_pulses", 256'(done_cnt), 256'(1));
        chk("beats", 256'(beats), 256'(exp_len));
        chk("drain_q_empty", 256'(drain_q.size()), 256'(0));
        chk("done_low", 256'(o_done), 256'(0));
        chk("busy_low", 256'(o_busy), 256'(0));
    endtask

    initial begin
        int n;
        total = 0; bad = 0; beats = 0; done_cnt = 0;
        rd_vld_exp = 0; rd_expect_next = 0; prev_stall = 0; prev_data = '0;
        rst = 1'b1;
        i_wr_en = 0; i_wr_addr = '0; i_wr_data = '0;
        i_rd_en = 0; i_rd_addr = '0;
        i_drain_start = 0; i_drain_count = '0; i_drain_ready = 1'b1;
        #12;
        chk("rst_rd_vld", 256'(o_rd_valid), 256'(0));
        chk("rst_rd_dat", o_rd_data, 256'(0));
        chk("rst_dv", 256'(o_drain_valid), 256'(0));
        chk("rst_dd", o_drain_data, 256'(0));
        chk("rst_busy", 256'(o_busy), 256'(0));
        chk("rst_done", 256'(o_done), 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Plain write then read with idle cycles around it.
        for (int i = 0; i < 4; i++) wr(i, row_of(16'(i + 1)));
        rd(2);
        tick();
        tick();

        // Same-cycle write and read of one address returns the written row.
        i_wr_en = 1'b1; i_wr_addr = 6'd5; i_wr_data = row_of(16'hABCD);
        model[5] = row_of(16'hABCD);
        i_rd_en = 1'b1; i_rd_addr = 6'd5;
        rd_q.push_back(row_of(16'hABCD));
        rd_expect_next = 1'b1;
        tick();
        i_wr_en = 1'b0; i_rd_en = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) wr(i, row_of(16'(16'h0010 + i)));
        drain(8, 1'b0, 1'b0, 8);

        for (int i = 0; i < 8; i++) wr(i, row_of(16'(16'h0020 + i)));
        drain(8, 1'b1, 1'b1, 8);

        drain(0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 64; i++) wr(i, row_of(16'(16'h0100 + i)));
        drain(100, 1'b0, 1'b0, 64);

        // Reset in the middle of a drain.
        for (int i = 0; i < 8; i++) drain_q.push_back(model[i]);
        beats = 0; done_cnt = 0;
        i_drain_count = 7'd8; i_drain_start = 1'b1;
        tick();
        i_drain_start = 1'b0;
        n = 0;
        while (beats < 3 && n < 50) begin
            tick();
            n++;
        end
        chk("pre_rst_timeout", 256'(n < 50), 256'(1));
        chk("pre_rst_busy", 256'(o_busy), 256'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_dv", 256'(o_drain_valid), 256'(0));
        chk("mid_rst_busy", 256'(o_busy), 256'(0));
        chk("mid_rst_done", 256'(o_done), 256'(0));
        drain_q.delete();
        prev_stall = 1'b0;
        rd_vld_exp = 1'b0;
        done_cnt = 0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("no_done_after_rst", 256'(done_cnt), 256'(0));
        drain(2, 1'b0, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
